// File: rtl/dec2bin_seq.sv
// dec2bin_seq: iterative 2-of-5 address-word to binary converter.
// Folds one decimal digit per clock (acc = acc*10 + d) behind valid/ready
// handshakes and reports invalid digit codes and arithmetic overflow.
// Optional feature: define DEC2BIN_ERRCNT_EN to add the o_errcnt port, a
// saturating count of completed transfers that carried o_err=1.
module dec2bin_seq #(
    parameter int NDIG  = 2,
    parameter int PBITS = 2,
    parameter int OW    = 9,
    localparam int IW   = PBITS + 5 * NDIG
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [IW-1:0] i_in,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_out,
    output logic          o_err,
`ifdef DEC2BIN_ERRCNT_EN
    output logic          o_ovf,
    output logic [7:0]    o_errcnt
`else
    output logic          o_ovf
`endif
);

    localparam int AW = OW + 4;
    localparam int SW = 5 * NDIG;
    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [SW-1:0]          sreg;
    logic [OW-1:0]          acc;
    logic [CW-1:0]          cnt;
    logic                   err;
    logic                   ovf;

    logic                   accept;
    logic                   step;
    logic                   xfer;

    logic [4:0]             code;
    logic [3:0]             dig;
    logic                   bad;
    logic [AW-1:0]          acc_w;
    logic [AW-1:0]          nxt;
    logic [PBITS+OW-1:0]    pre_ext;
    logic                   pre_ovf;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    xfer      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decode the top digit field and form acc*10 + d with shifts
    always_comb begin
        code = sreg[SW-1 -: 5];
        bad  = 1'b0;
        dig  = 4'd0;
        case (code)
            5'b00011: dig = 4'd0;  // de
            5'b10010: dig = 4'd1;  // ad
            5'b10001: dig = 4'd2;  // ae
            5'b01001: dig = 4'd3;  // be
            5'b11000: dig = 4'd4;  // ab
            5'b10100: dig = 4'd5;  // ac
            5'b01100: dig = 4'd6;  // bc
            5'b01010: dig = 4'd7;  // bd
            5'b00110: dig = 4'd8;  // cd
            5'b00101: dig = 4'd9;  // ce
            default:  bad = 1'b1;
        endcase
        acc_w   = {4'b0000, acc};
        nxt     = (acc_w << 3) + (acc_w << 1) + AW'(dig);
        pre_ext = {{OW{1'b0}}, i_in[IW-1 -: PBITS]};
        pre_ovf = |(pre_ext >> OW);
    end

    // Datapath: load on accept, fold one digit per RUN cycle.
    // The accumulator keeps only OW bits; any carry out is recorded as sticky ovf,
    // so the result is the true value modulo 2**OW.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sreg <= '0;
            acc  <= '0;
            cnt  <= '0;
            err  <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            sreg <= i_in[SW-1:0];
            acc  <= pre_ext[OW-1:0];
            cnt  <= CW'(NDIG);
            err  <= 1'b0;
            ovf  <= pre_ovf;
        end else if (step) begin
            sreg <= sreg << 5;
            acc  <= nxt[OW-1:0];
            cnt  <= cnt - CW'(1);
            err  <= err | bad;
            ovf  <= ovf | (|nxt[AW-1:OW]);
        end
    end

    assign o_out = acc;
    assign o_err = err;
    assign o_ovf = ovf;

`ifdef DEC2BIN_ERRCNT_EN
    // Saturating count of erroneous results handed to the consumer
    always_ff @(posedge i_clk) begin
        if (i_reset)                                 o_errcnt <= '0;
        else if (xfer && err && (o_errcnt != 8'hFF)) o_errcnt <= o_errcnt + 8'd1;
    end
`endif

endmodule
